// File: rtl/ifu_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pc_unit_pkg
//   Shared address-map and next-PC constants for the instruction fetch unit.
//
//   Contents:
//     npc_sel_e           - next-PC mode encoding driven by the decode stage
//     *_DEFAULT constants - reset PC, exception handler entry and the legal
//                           instruction-memory window
//     branch_disp()       - sign-extended, word-scaled branch displacement
//     is_link()           - true for the modes that write a return address
// ---------------------------------------------------------------------------
package ifu_pc_unit_pkg;

  // Next-PC mode selected by the decode stage. NPC_RSVD behaves as NPC_SEQ.
  typedef enum logic [2:0] {
    NPC_SEQ    = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_J      = 3'b010,
    NPC_JR     = 3'b011,
    NPC_JAL    = 3'b100,
    NPC_JALR   = 3'b101,
    NPC_RET    = 3'b110,
    NPC_RSVD   = 3'b111
  } npc_sel_e;

  // Address map of the fetch side.
  localparam logic [31:0] PC_INIT_DEFAULT      = 32'h0000_3000;
  localparam logic [31:0] HANDLE_START_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEFAULT      = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES_DEFAULT     = 32'h0000_4000;

  // Branch immediates count instructions, so the displacement is the
  // sign-extended offset scaled by four.
  function automatic logic [31:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

  // jal and jalr are the only modes that produce a return address.
  function automatic logic is_link(input logic [2:0] sel);
    return (sel == NPC_JAL) || (sel == NPC_JALR);
  endfunction

endpackage

// File: rtl/ifu_ras.sv
// ---------------------------------------------------------------------------
// ifu_ras
//   Circular return-address stack. A push when full overwrites the oldest
//   entry; a pop when empty is ignored. Entry storage is not reset -- only
//   the pointer and count are, and the top reads as 0 while count is 0.
//
//   Parameters:
//     ADDR_W - width of a stored address
//     DEPTH  - number of entries (power of two, 2..16)
//
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     push        - write push_data as the new top entry
//     pop         - discard the top entry
//     push_data   - return address to store
//     top         - most recent valid entry, 0 when empty
//     count       - number of valid entries, saturates at DEPTH
// ---------------------------------------------------------------------------
module ifu_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [ADDR_W-1:0]       push_data,
  output logic [ADDR_W-1:0]       top,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] entries [DEPTH];

  // ptr is the slot the next push writes; the top entry sits one below it.
  // Because DEPTH is a power of two the pointer wraps naturally, which is
  // what makes an overflowing push replace the oldest entry.
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic             empty;
  logic             full;

  assign top_idx = ptr - PTR_ONE;
  assign empty   = (count == '0);
  assign full    = (count == COUNT_FULL);

  // Pointer and occupancy. The fetch unit never pushes and pops in the same
  // cycle; if it ever did, the push would take effect and the pop would be
  // dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  // Entry storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[ptr] <= push_data;
    end
  end

  assign top = empty ? '0 : entries[top_idx];

endmodule

// File: rtl/ifu_pc_unit.sv
// ---------------------------------------------------------------------------
// ifu_pc_unit
//   Fetch-stage program counter with next-PC selection, exception redirect,
//   fetch address checking and a return-address stack used to predict
//   "jr $ra" targets. The PC always follows the resolved target; the stack
//   only reports whether its prediction would have been right.
//
//   Parameters:
//     ADDR_W       - PC width (29..32)
//     PC_INIT      - PC loaded on reset
//     HANDLE_START - exception handler entry
//     IM_BASE      - lowest legal fetch address
//     IM_BYTES     - size of the legal fetch window
//     RAS_DEPTH    - return-address-stack entries (power of two, 2..16)
//
//   Ports:
//     clk, reset   - clock, asynchronous active-high reset
//     stall        - hold the F-stage PC
//     req          - exception redirect to HANDLE_START (overrides stall)
//     eret         - return from exception to epc
//     epc          - exception return address
//     npc_sel      - next-PC mode (see npc_sel_e)
//     branch_taken - branch compare result from decode
//     pc_d         - address of the instruction in decode
//     offset       - branch immediate
//     instr_index  - jump index
//     rs_val       - register jump target
//     pc           - current fetch PC
//     adel         - fetch address error (misaligned or outside the window)
//     ras_top      - predicted return target
//     ras_count    - valid stack entries
//     ras_miss     - one-cycle flag: the last accepted return was mispredicted
// ---------------------------------------------------------------------------
module ifu_pc_unit
  import ifu_pc_unit_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] PC_INIT      = PC_INIT_DEFAULT,
  parameter logic [31:0] HANDLE_START = HANDLE_START_DEFAULT,
  parameter logic [31:0] IM_BASE      = IM_BASE_DEFAULT,
  parameter logic [31:0] IM_BYTES     = IM_BYTES_DEFAULT,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       req,
  input  logic                       eret,
  input  logic [ADDR_W-1:0]          epc,
  input  logic [2:0]                 npc_sel,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          pc_d,
  input  logic [15:0]                offset,
  input  logic [25:0]                instr_index,
  input  logic [ADDR_W-1:0]          rs_val,
  output logic [ADDR_W-1:0]          pc,
  output logic                       adel,
  output logic [ADDR_W-1:0]          ras_top,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_miss
);

  localparam logic [ADDR_W-1:0] PC_RESET   = PC_INIT[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] HANDLER_PC = HANDLE_START[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] INCR_4     = {{(ADDR_W-3){1'b0}}, 3'd4};
  localparam logic [ADDR_W-1:0] INCR_8     = {{(ADDR_W-4){1'b0}}, 4'd8};

  // The window bounds are compared one bit wider than 32 so that a window
  // ending exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] WIN_LO = {1'b0, IM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] link_pc;
  logic [31:0]       disp;
  logic [32:0]       pc_wide;

  logic accepted;
  logic ras_push;
  logic ras_pop;
  logic ras_empty;

  // ---------------------------------------------------------------------
  // Candidate targets
  // ---------------------------------------------------------------------
  assign disp    = branch_disp(offset);
  assign seq_pc  = pc + INCR_4;
  assign jump_pc = {pc_d[ADDR_W-1:28], instr_index, 2'b00};
  assign link_pc = pc_d + INCR_8;

  // A not-taken branch falls through from the fetch PC, not from pc_d.
  assign branch_pc = branch_taken ? (pc_d + INCR_4 + disp[ADDR_W-1:0]) : seq_pc;

  // Target chosen by the decode-stage mode. Returns always follow rs_val;
  // the stack is a predictor only and never steers the PC.
  always_comb begin
    target_pc = seq_pc;
    case (npc_sel)
      NPC_SEQ:    target_pc = seq_pc;
      NPC_BRANCH: target_pc = branch_pc;
      NPC_J:      target_pc = jump_pc;
      NPC_JAL:    target_pc = jump_pc;
      NPC_JR:     target_pc = rs_val;
      NPC_JALR:   target_pc = rs_val;
      NPC_RET:    target_pc = rs_val;
      default:    target_pc = seq_pc;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-PC priority: exception redirect beats everything (including a
  // stall), then stall holds, then eret, then the decoded target.
  // ---------------------------------------------------------------------
  always_comb begin
    next_pc = target_pc;
    if (req) begin
      next_pc = HANDLER_PC;
    end else if (stall) begin
      next_pc = pc;
    end else if (eret) begin
      next_pc = epc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_RESET;
    end else begin
      pc <= next_pc;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch address check
  // ---------------------------------------------------------------------
  assign pc_wide = {{(33-ADDR_W){1'b0}}, pc};
  assign adel    = (pc[1:0] != 2'b00) || (pc_wide < WIN_LO) || (pc_wide >= WIN_HI);

  // ---------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------
  // The stack only moves when the decoded control transfer is the one that
  // actually steers the PC this cycle.
  assign accepted  = !req && !stall && !eret;
  assign ras_push  = accepted && is_link(npc_sel);
  assign ras_pop   = accepted && (npc_sel == NPC_RET);
  assign ras_empty = (ras_count == '0);

  ifu_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_pc),
    .top       (ras_top),
    .count     (ras_count)
  );

  // The prediction is judged against the top as it stood before the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_miss <= 1'b0;
    end else begin
      ras_miss <= ras_pop && (ras_empty || (ras_top != rs_val));
    end
  end

endmodule

// File: tb/tb_ifu_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_ifu_pc_unit
//   Self-checking bench for ifu_pc_unit: a directed vector table, hand
//   sequences for stack overflow/underflow and reset during a stall, then
//   random traffic compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ifu_pc_unit;
  import ifu_pc_unit_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int RAS_DEPTH = 4;
  localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              req;
  logic              eret;
  logic [31:0]       epc;
  logic [2:0]        npc_sel;
  logic              branch_taken;
  logic [31:0]       pc_d;
  logic [15:0]       offset;
  logic [25:0]       instr_index;
  logic [31:0]       rs_val;
  logic [31:0]       pc;
  logic              adel;
  logic [31:0]       ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_miss;

  int total = 0;
  int bad   = 0;

  // Reference model state: the stack is a queue with the newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_miss;

  always #5 clk = ~clk;

  ifu_pc_unit #(
    .ADDR_W       (ADDR_W),
    .PC_INIT      (32'h0000_3000),
    .HANDLE_START (32'h0000_4180),
    .IM_BASE      (32'h0000_3000),
    .IM_BYTES     (32'h0000_4000),
    .RAS_DEPTH    (RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .pc_d         (pc_d),
    .offset       (offset),
    .instr_index  (instr_index),
    .rs_val       (rs_val),
    .pc           (pc),
    .adel         (adel),
    .ras_top      (ras_top),
    .ras_count    (ras_count),
    .ras_miss     (ras_miss)
  );

  typedef struct {
    logic        s;
    logic        r;
    logic        e;
    logic [2:0]  sel;
    logic        taken;
    logic [31:0] ep;
    logic [31:0] pd;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] rv;
    logic [31:0] x_pc;
    logic        x_adel;
    logic [31:0] x_top;
    int          x_cnt;
    logic        x_miss;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mkv(
    input logic s, input logic r, input logic e, input logic [2:0] sel,
    input logic taken, input logic [31:0] ep, input logic [31:0] pd,
    input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rv,
    input logic [31:0] x_pc, input logic x_adel, input logic [31:0] x_top,
    input int x_cnt, input logic x_miss);
    vec_t v;
    v.s = s; v.r = r; v.e = e; v.sel = sel; v.taken = taken;
    v.ep = ep; v.pd = pd; v.off = off; v.idx = idx; v.rv = rv;
    v.x_pc = x_pc; v.x_adel = x_adel; v.x_top = x_top;
    v.x_cnt = x_cnt; v.x_miss = x_miss;
    return v;
  endfunction

  function automatic logic model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h7000);
  endfunction

  function automatic logic [31:0] model_top();
    if (m_ras.size() == 0) return 32'h0;
    return m_ras[m_ras.size()-1];
  endfunction

  // One clock of the architectural rules, written directly from the
  // behaviour of each mode rather than from any hardware structure.
  task automatic modelStep(
    input logic s, input logic r, input logic e, input logic [2:0] sel,
    input logic taken, input logic [31:0] ep, input logic [31:0] pd,
    input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rv);
    logic [31:0] nxt;
    m_miss = 1'b0;
    if (r) begin
      nxt = 32'h4180;
    end else if (s) begin
      nxt = m_pc;
    end else if (e) begin
      nxt = ep;
    end else begin
      case (sel)
        3'd1: nxt = taken ? pd + 32'd4 + 32'($signed(off)) * 32'd4 : m_pc + 32'd4;
        3'd2, 3'd4: nxt = {pd[31:28], idx, 2'b00};
        3'd3, 3'd5, 3'd6: nxt = rv;
        default: nxt = m_pc + 32'd4;
      endcase
      if (sel == 3'd4 || sel == 3'd5) begin
        m_ras.push_back(pd + 32'd8);
        if (m_ras.size() > RAS_DEPTH) m_ras.pop_front();
      end
      if (sel == 3'd6) begin
        if (m_ras.size() == 0) begin
          m_miss = 1'b1;
        end else begin
          m_miss = (m_ras[m_ras.size()-1] != rv);
          m_ras.pop_back();
        end
      end
    end
    m_pc = nxt;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] x_pc, input logic x_adel,
                             input logic [31:0] x_top, input int x_cnt, input logic x_miss);
    checkOne({tag, ".pc"},        pc,             x_pc);
    checkOne({tag, ".adel"},      32'(adel),      32'(x_adel));
    checkOne({tag, ".ras_top"},   ras_top,        x_top);
    checkOne({tag, ".ras_count"}, 32'(ras_count), 32'(x_cnt));
    checkOne({tag, ".ras_miss"},  32'(ras_miss),  32'(x_miss));
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, m_pc, model_adel(m_pc), model_top(), m_ras.size(), m_miss);
  endtask

  // Drives one cycle of inputs, advances the model, and returns #1 after
  // the edge so outputs can be sampled clear of it.
  task automatic applyStimulus(
    input logic s, input logic r, input logic e, input logic [2:0] sel,
    input logic taken, input logic [31:0] ep, input logic [31:0] pd,
    input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rv);
    stall = s; req = r; eret = e; npc_sel = sel; branch_taken = taken;
    epc = ep; pc_d = pd; offset = off; instr_index = idx; rs_val = rv;
    modelStep(s, r, e, sel, taken, ep, pd, off, idx, rv);
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    stall = 0; req = 0; eret = 0; npc_sel = NPC_SEQ; branch_taken = 0;
    epc = 0; pc_d = 0; offset = 0; instr_index = 0; rs_val = 0;
  endtask

  task automatic modelReset();
    m_pc = 32'h3000;
    m_ras.delete();
    m_miss = 1'b0;
  endtask

  initial begin
    logic [31:0] pd;
    logic [31:0] rv;
    logic        s, r, e, t;
    logic [2:0]  sel;

    idleInputs();
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 32'h3000, 1'b0, 32'h0, 0, 1'b0);
    reset = 1'b0;

    // s r e sel taken epc pc_d offset idx rs_val | pc adel top cnt miss
    vecs.push_back(mkv(0,0,0,NPC_SEQ,   0,0,0,0,0,0,                       32'h3004,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_SEQ,   0,0,0,0,0,0,                       32'h3008,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_BRANCH,1,0,32'h3010,16'hFFFC,0,0,         32'h3004,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_JR,    0,0,0,0,0,32'h3014,                32'h3014,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_BRANCH,0,0,32'h3010,16'hFFFC,0,0,         32'h3018,0,0,0,0));
    vecs.push_back(mkv(1,1,1,NPC_SEQ,   0,32'h3020,0,0,0,0,                32'h4180,0,0,0,0));
    vecs.push_back(mkv(1,0,0,NPC_SEQ,   0,0,0,0,0,0,                       32'h4180,0,0,0,0));
    vecs.push_back(mkv(0,0,1,NPC_SEQ,   0,32'h3020,0,0,0,0,                32'h3020,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_JAL,   0,0,32'h3000,0,26'hC40,0,          32'h3100,0,32'h3008,1,0));
    vecs.push_back(mkv(0,0,0,NPC_RET,   0,0,0,0,0,32'h3008,                32'h3008,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_SEQ,   0,0,0,0,0,0,                       32'h300C,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_RET,   0,0,0,0,0,32'h300C,                32'h300C,0,0,0,1));
    vecs.push_back(mkv(0,0,0,NPC_SEQ,   0,0,0,0,0,0,                       32'h3010,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_JR,    0,0,0,0,0,32'h3002,                32'h3002,1,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_JR,    0,0,0,0,0,32'h7000,                32'h7000,1,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_J,     0,0,32'h3000,0,26'hC00,0,          32'h3000,0,0,0,0));
    vecs.push_back(mkv(0,0,0,NPC_JALR,  0,0,32'h3020,0,0,32'h3040,         32'h3040,0,32'h3028,1,0));
    vecs.push_back(mkv(1,0,0,NPC_JAL,   0,0,32'h3100,0,26'hC40,0,          32'h3040,0,32'h3028,1,0));
    vecs.push_back(mkv(0,1,0,NPC_JAL,   0,0,32'h3100,0,26'hC40,0,          32'h4180,0,32'h3028,1,0));
    vecs.push_back(mkv(0,0,1,NPC_RET,   0,32'h3030,0,0,0,32'h3000,         32'h3030,0,32'h3028,1,0));
    vecs.push_back(mkv(0,0,0,NPC_RSVD,  0,0,0,0,0,0,                       32'h3034,0,32'h3028,1,0));
    vecs.push_back(mkv(0,0,0,NPC_RET,   0,0,0,0,0,32'h3000,                32'h3000,0,0,0,1));
    vecs.push_back(mkv(0,0,0,NPC_SEQ,   0,0,0,0,0,0,                       32'h3004,0,0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].r, vecs[i].e, vecs[i].sel, vecs[i].taken,
                    vecs[i].ep, vecs[i].pd, vecs[i].off, vecs[i].idx, vecs[i].rv);
      checkOutput($sformatf("vec%0d", i), vecs[i].x_pc, vecs[i].x_adel,
                  vecs[i].x_top, vecs[i].x_cnt, vecs[i].x_miss);
    end

    // Overflow: five pushes into a four-deep stack keep pushes 2..5.
    for (int i = 0; i < 5; i++) begin
      pd = 32'h3100 + 32'(i) * 32'h100;
      applyStimulus(0, 0, 0, NPC_JAL, 0, 0, pd, 0, 26'hC40, 0);
      checkOutput($sformatf("push%0d", i), 32'h3100, 1'b0, pd + 32'd8,
                  (i + 1 > 4) ? 4 : i + 1, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      rv = 32'h3508 - 32'(k) * 32'h100;
      applyStimulus(0, 0, 0, NPC_RET, 0, 0, 0, 0, 0, rv);
      checkOutput($sformatf("pop%0d", k), rv, 1'b0,
                  (k < 3) ? rv - 32'h100 : 32'h0, 3 - k, 1'b0);
    end
    applyStimulus(0, 0, 0, NPC_RET, 0, 0, 0, 0, 0, 32'h3108);
    checkOutput("pop_empty", 32'h3108, 1'b0, 32'h0, 0, 1'b1);
    applyStimulus(0, 0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0);
    checkOutput("after_empty", 32'h310C, 1'b0, 32'h0, 0, 1'b0);

    // Reset arriving in the middle of a stall takes effect without a clock.
    applyStimulus(0, 0, 0, NPC_JAL, 0, 0, 32'h3200, 0, 26'hC80, 0);
    checkOutput("pre_stall", 32'h3200, 1'b0, 32'h3208, 1, 1'b0);
    applyStimulus(1, 0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_hold", 32'h3200, 1'b0, 32'h3208, 1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_stall", 32'h3000, 1'b0, 32'h0, 0, 1'b0);
    modelReset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    idleInputs();
    #3;
    checkOutput("reset_held", 32'h3000, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(0, 0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0);
    checkOutput("resume", 32'h3004, 1'b0, 32'h0, 0, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 19) == 0);
      s   = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 14) == 0);
      t   = 1'($urandom_range(0, 1));
      sel = 3'($urandom_range(0, 7));
      pd  = 32'h3000 + 32'($urandom_range(0, 12'hFFF)) * 32'd4;
      if (sel == NPC_RET && m_ras.size() != 0 && $urandom_range(0, 2) != 0)
        rv = m_ras[m_ras.size()-1];
      else if ($urandom_range(0, 9) == 0)
        rv = $urandom;
      else
        rv = 32'h3000 + 32'($urandom_range(0, 12'hFFF)) * 32'd4;
      applyStimulus(s, r, e, sel, t,
                    32'h3000 + 32'($urandom_range(0, 12'hFFF)) * 32'd4, pd,
                    16'($urandom), 26'($urandom_range(26'hC00, 26'h1BFF)), rv);
      checkModel($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_pc_unit.md
IFU_PC_UNIT -- requirements
Module: ifu_pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC width; legal range 29..32.
REQ-002 SHALL have parameter PC_INIT, default 32'h0000_3000, meaning reset PC.
REQ-003 SHALL have parameter HANDLE_START, default 32'h0000_4180, meaning exception handler entry.
REQ-004 SHALL have parameter IM_BASE, default 32'h0000_3000, meaning lowest legal fetch address.
REQ-005 SHALL have parameter IM_BYTES, default 32'h0000_4000, meaning legal fetch window size.
REQ-006 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries; power of two, 2..16.
REQ-007 SHALL have ports: clk  in  1  clock; reset  in  1  async, active-high.
REQ-008 SHALL have ports: stall  in  1  hold F-stage PC; req  in  1  exception redirect; eret  in  1  return from exception; epc  in  ADDR_W  EPC value.
REQ-009 SHALL have ports: npc_sel  in  3  next-PC mode; branch_taken  in  1  branch compare result; pc_d  in  ADDR_W  D-stage instruction address.
REQ-010 SHALL have ports: offset  in  16  branch immediate; instr_index  in  26  jump index; rs_val  in  ADDR_W  register target.
REQ-011 SHALL have ports: pc  out  ADDR_W  current fetch PC; adel  out  1  fetch address error; ras_top  out  ADDR_W  predicted return target; ras_count  out  $clog2(RAS_DEPTH)+1  valid entries; ras_miss  out  1  one-cycle return mispredict flag.

Function
REQ-012 SHALL encode npc_sel: 000 seq, 001 branch, 010 j, 011 jr, 100 jal, 101 jalr, 110 ret (jr $ra), 111 reserved, treated as seq.
REQ-013 SHALL compute targets: seq = pc+4; branch = branch_taken ? pc_d+4+(sext(offset)<<2) : pc+4; j/jal = {pc_d[ADDR_W-1:28], instr_index, 2'b00}; jr/jalr/ret = rs_val; all arithmetic modulo 2^ADDR_W.
REQ-014 SHALL update pc on each rising clk with priority: req -> HANDLE_START (ignores stall); else stall -> hold; else eret -> epc; else target per npc_sel.
REQ-015 SHALL have one-cycle latency: the target selected in cycle n is on pc in cycle n+1.
REQ-016 SHALL push pc_d+8 onto the RAS on accepted jal/jalr (not stalled, no req, no eret).
REQ-017 SHALL pop the RAS on accepted ret; the redirect always uses rs_val, never the RAS.
REQ-018 SHALL, when full, overwrite the oldest entry on push (circular); ras_count saturates at RAS_DEPTH.
REQ-019 SHALL, on pop when empty, leave ras_count at 0 and the pointer unchanged.
REQ-020 SHALL drive ras_miss high for exactly the cycle after an accepted ret when ras_count was 0 or ras_top != rs_val; otherwise low.
REQ-021 SHALL drive ras_top = most recent valid entry, or 0 when ras_count is 0.
REQ-022 SHALL drive adel combinationally from pc: high when pc[1:0] != 0, pc < IM_BASE, or pc >= IM_BASE+IM_BYTES.
REQ-023 SHALL leave the RAS unchanged on stall, req, or eret cycles.

Reset
REQ-024 SHALL, on reset assertion (asynchronous, any time including mid-stall), set pc = PC_INIT, ras_count = 0, RAS pointer = 0, ras_miss = 0.
REQ-025 SHALL leave RAS entry contents unreset; they are unobservable while ras_count is 0.
REQ-026 SHALL resume normal operation on the first rising clk after reset deasserts.

Structure
REQ-027 SHALL place npc_sel encodings, PC_INIT, HANDLE_START, IM_BASE and IM_BYTES in the shared address-map/constants package.
REQ-028 SHALL implement the stack as one sub-module, ifu_ras (push, pop, top, count, parametrised by ADDR_W and RAS_DEPTH).

Verification
REQ-029 SHALL cover reset then free run: pc = 3000, 3004, 3008 on successive cycles; adel = 0.
REQ-030 SHALL cover branch: pc_d = 3010, offset = 16'hFFFC, taken -> next pc = 3004; not taken from pc = 3014 -> 3018.
REQ-031 SHALL cover priority: req = 1 with stall = 1 and eret = 1 -> pc = 4180; stall alone holds pc; eret with epc = 3020 -> pc = 3020.
REQ-032 SHALL cover RAS: jal at pc_d = 3000 -> ras_top = 3008, count = 1; ret with rs_val = 3008 -> ras_miss = 0, count = 0; ret with rs_val = 300C -> ras_miss = 1.
REQ-033 SHALL cover overflow: with depth 4, five jal pushes -> count = 4 and top = 5th push; five rets -> the 5th ret flags ras_miss, count stays 0.
REQ-034 SHALL cover address error: jr with rs_val = 3002 -> adel = 1; rs_val = 7000 -> adel = 1; reset asserted mid-stall -> pc = 3000 immediately.
